// File: rtl/aes_inv_key_sched.sv
// Reverse-order AES-128 round-key generator: takes the round-10 key and
// streams round keys 10..0 on a valid/ready interface by inverting the expansion.

module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] s
);
   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] p, m;
      p = 8'h00;
      m = x;
      for (int i = 0; i < 8; i++) begin
         if (y[i]) p = p ^ m;
         m = {m[6:0], 1'b0} ^ (m[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   logic [7:0] t, inv;

   // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128), then the affine map.
   always_comb begin
      t   = a;
      inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         t   = gf_mul(t, t);
         inv = gf_mul(inv, t);
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end
endmodule

module aes_inv_key_sched #(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] last_key_in,
   output logic [127:0] round_key,
   output logic [3:0]   round_idx,
   output logic         key_valid,
   input  logic         key_ready,
   output logic         busy,
   output logic         done
);
   localparam logic [3:0] LAST_IDX = 4'(NR);

   typedef enum logic {IDLE, OUT} state_t;

   state_t         state, state_nxt;
   logic [127:0]   key_reg, key_nxt;
   logic [3:0]     idx, idx_nxt;
   logic           done_nxt;
   logic [31:0]    a0, a1, a2, a3, b0, b1, b2, b3;
   logic [31:0]    rot, sub;
   logic [7:0]     rc;
   logic [127:0]   prev_key;

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   assign {a0, a1, a2, a3} = key_reg;
   assign b3  = a3 ^ a2;
   assign b2  = a2 ^ a1;
   assign b1  = a1 ^ a0;
   assign rot = {b3[23:0], b3[31:24]};
   assign rc  = rcon(idx);

   for (genvar g = 0; g < 4; g++) begin : g_sbox
      aes_sbox u_sbox (.a(rot[g*8 +: 8]), .s(sub[g*8 +: 8]));
   end

   assign b0       = a0 ^ sub ^ {rc, 24'h0};
   assign prev_key = {b0, b1, b2, b3};

   always_comb begin
      state_nxt = state;
      key_nxt   = key_reg;
      idx_nxt   = idx;
      done_nxt  = 1'b0;
      case (state)
         IDLE: if (start) begin
            key_nxt   = last_key_in;
            idx_nxt   = LAST_IDX;
            state_nxt = OUT;
         end
         OUT: if (key_ready) begin
            if (idx != 4'd0) begin
               key_nxt = prev_key;
               idx_nxt = idx - 4'd1;
            end else begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         key_reg <= 128'h0;
         idx     <= 4'd0;
         done    <= 1'b0;
      end else begin
         state   <= state_nxt;
         key_reg <= key_nxt;
         idx     <= idx_nxt;
         done    <= done_nxt;
      end
   end

   assign round_key = key_reg;
   assign round_idx = idx;
   assign key_valid = (state == OUT);
   assign busy      = (state == OUT);
endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Self-checking bench for aes_inv_key_sched against a forward key-expansion model.

module tb_aes_inv_key_sched;
   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [127:0] last_key_in;
   logic [127:0] round_key;
   logic [3:0]   round_idx;
   logic         key_valid;
   logic         key_ready;
   logic         busy;
   logic         done;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0]   sb [0:255];
   logic [127:0] rk [0:10];

   always #5 clk = ~clk;

   aes_inv_key_sched #(.NR(10)) dut (
      .clk(clk), .rst(rst), .start(start), .last_key_in(last_key_in),
      .round_key(round_key), .round_idx(round_idx), .key_valid(key_valid),
      .key_ready(key_ready), .busy(busy), .done(done)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // S-box from the generator-3 log walk, independent of any inverse computation.
   task automatic build_sbox();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b0};
         q = q ^ {q[3:0], 4'b0};
         if (q[7]) q = q ^ 8'h09;
         x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
         sb[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sb[0] = 8'h63;
   endtask

   // Standard forward expansion from the cipher key; rk[r] is round key r.
   task automatic expand(input logic [127:0] k0);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      {w[0], w[1], w[2], w[3]} = k0;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
            t = t ^ {rc, 24'h0};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic do_start(input logic [127:0] k);
      start       = 1'b1;
      last_key_in = k;
      @(negedge clk);
   endtask

   // Walks one stream from the negedge after start. Optional events: stray start at
   // busy_at, reset at rst_at, and a back-to-back start (b2b) in the done cycle.
   task automatic stream(input int rdy_pct, input int busy_at, input int rst_at,
                         input bit b2b, input logic [127:0] nxt, input bit chk_tput);
      int e, cyc;
      bit rdy, fin;
      e   = 10;
      cyc = 0;
      fin = 1'b0;
      while (!fin && cyc < 400) begin
         cyc++;
         chk("valid", {127'h0, key_valid}, 128'h1);
         chk("busy", {127'h0, busy}, 128'h1);
         chk("done_lo", {127'h0, done}, 128'h0);
         chk("idx", {124'h0, round_idx}, 128'(e));
         chk($sformatf("key%0d", e), round_key, rk[e]);
         if (e == rst_at) begin
            start = 1'b0;
            rst   = 1'b1;
            @(negedge clk);
            rst   = 1'b0;
            chk("rst_valid", {127'h0, key_valid}, 128'h0);
            chk("rst_busy", {127'h0, busy}, 128'h0);
            chk("rst_done", {127'h0, done}, 128'h0);
            chk("rst_idx", {124'h0, round_idx}, 128'h0);
            chk("rst_key", round_key, 128'h0);
            return;
         end
         if (e == busy_at) begin
            start       = 1'b1;
            last_key_in = {$urandom, $urandom, $urandom, $urandom};
         end else begin
            start = 1'b0;
         end
         rdy       = ($urandom_range(0, 99) < rdy_pct);
         key_ready = rdy;
         @(negedge clk);
         if (rdy) begin
            if (e == 0) fin = 1'b1;
            else e--;
         end
      end
      if (!fin) begin
         chk("timeout", 128'h0, 128'h1);
         return;
      end
      if (chk_tput) chk("tput", 128'(cyc), 128'd11);
      chk("done_hi", {127'h0, done}, 128'h1);
      chk("end_valid", {127'h0, key_valid}, 128'h0);
      chk("end_busy", {127'h0, busy}, 128'h0);
      if (b2b) begin
         start       = 1'b1;
         last_key_in = nxt;
      end else begin
         start = 1'b0;
      end
      key_ready = 1'b0;
      @(negedge clk);
      chk("done_pulse", {127'h0, done}, 128'h0);
   endtask

   initial begin
      logic [127:0] k0;
      rst         = 1'b1;
      start       = 1'b0;
      key_ready   = 1'b0;
      last_key_in = '0;
      build_sbox();
      repeat (3) @(negedge clk);
      chk("r_valid", {127'h0, key_valid}, 128'h0);
      chk("r_busy", {127'h0, busy}, 128'h0);
      chk("r_done", {127'h0, done}, 128'h0);
      chk("r_idx", {124'h0, round_idx}, 128'h0);
      chk("r_key", round_key, 128'h0);
      rst = 1'b0;
      @(negedge clk);

      // FIPS-197 A.1, full throughput; DUT driven with the literal round-10 key.
      expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
      chk("fips_k9", rk[9], 128'hac7766f319fadc2128d12941575c006e);
      do_start(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      stream(100, -1, -1, 1'b0, '0, 1'b1);

      // Same vector under random backpressure.
      do_start(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      stream(50, -1, -1, 1'b0, '0, 1'b0);

      // Stray start at idx 5 must be ignored.
      do_start(rk[10]);
      stream(70, 5, -1, 1'b0, '0, 1'b0);

      // Reset at idx 4, then a fresh start.
      do_start(rk[10]);
      stream(60, -1, 4, 1'b0, '0, 1'b0);
      do_start(rk[10]);
      stream(100, -1, -1, 1'b1, 128'h13111d7fe3944a17f307a78b4d2b30c5, 1'b1);

      // Back-to-back: start landed in the done cycle, so the stream is already live.
      expand(128'h000102030405060708090a0b0c0d0e0f);
      stream(60, -1, -1, 1'b0, '0, 1'b0);

      // Random keys, random backpressure.
      for (int n = 0; n < 4; n++) begin
         k0 = {$urandom, $urandom, $urandom, $urandom};
         expand(k0);
         do_start(rk[10]);
         stream((n == 0) ? 100 : 40, -1, -1, 1'b0, '0, n == 0);
      end

      // Idle with key_ready high and no start.
      key_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk("idle_valid", {127'h0, key_valid}, 128'h0);
         chk("idle_busy", {127'h0, busy}, 128'h0);
         chk("idle_done", {127'h0, done}, 128'h0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/aes_inv_key_sched.md
# aes_inv_key_sched

Reverse-order AES-128 round-key generator for the decryption datapath. The encryption side consumes round keys 0→10. Decryption applies AddRoundKey with keys 10→0, so this block takes the final (round-10) key and regenerates each earlier key by inverting the key expansion, one key per handshake. Each key is presented on a valid/ready stream to the inverse-round pipeline.

## Interface
Parameters:
- NR, 10, number of AES rounds; fixed for AES-128, not to be overridden.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle request; captures last_key_in when idle.
- last_key_in  input  128  round-10 key; [127:96]=w0 … [31:0]=w3, byte 0 at [127:120].
- round_key  output  128  current round key, same packing.
- round_idx  output  4  round number of round_key (10 down to 0).
- key_valid  output  1  round_key/round_idx valid.
- key_ready  input  1  downstream accepts the key on this edge when key_valid is also high.
- busy  output  1  high from capture until the last key is accepted.
- done  output  1  one-cycle pulse after round-0 key accepted.

## Operation
- Clock and reset: one clock; reset is synchronous and active-high.
- FSM states: IDLE, OUT.
- IDLE:
  - start=1 → load key_reg=last_key_in, idx=10, go OUT.
  - start=0 → stay IDLE.
- OUT:
  - key_valid=1.
  - Handshake with idx>0 → key_reg=prev(key_reg), idx−1, stay OUT.
  - Handshake with idx=0 → go IDLE, pulse done.
  - No handshake → hold key_reg and idx unchanged.
- prev(K), K={a0,a1,a2,a3} at round r:
  - b3=a3^a2.
  - b2=a2^a1.
  - b1=a1^a0.
  - b0=a0^SubWord(RotWord(b3))^{rc_r,24'h0}.
- RotWord(x)={x[23:0],x[31:24]}.
- SubWord: the forward AES S-box on each byte. Four combinational instances are internal to the block.
- rc_r for r=1..10: 01,02,04,08,10,20,40,80,1b,36. Indexed by the current idx, i.e. the round being left.
- prev() is purely combinational from key_reg, evaluated and registered in the handshake cycle.
- start while busy (OUT): ignored, no recapture.
- start in the same cycle done is asserted: accepted. The block is in IDLE that cycle.
- Reset mid-stream: next cycle IDLE, stream abandoned, no done pulse.

## Timing
- Reset values:
  - key_valid=0, busy=0, done=0.
  - round_idx=0.
  - round_key=128'h0.
  - FSM=IDLE.
- Start latency: start sampled at edge T → key_valid=1, round_idx=10, round_key=last_key_in from after T.
- Throughput: with key_ready held high, 11 keys in 11 consecutive cycles (idx 10..0).
- Stall: key_valid never drops without a handshake. round_key and round_idx are stable while key_valid & !key_ready.
- After the round-0 handshake at edge E:
  - key_valid=0 and busy=0 after E.
  - done=1 for exactly the cycle after E.
- All outputs are registered; no combinational path from key_ready to the outputs.
- key_ready while key_valid=0: no effect.

## Test plan
- FIPS-197 A.1 vector:
  - Stimulus: start with last_key_in=d014f9a8c9ee2589e13f0cc8b6630ca6, key_ready=1.
  - Response: idx10 shows that value; idx9=ac7766f319fadc2128d12941575c006e; idx0=2b7e151628aed2a6abf7158809cf4f3c.
  - done pulses in the cycle after idx0 is accepted.
- Random backpressure:
  - Stimulus: same vector, key_ready toggled pseudo-randomly.
  - Response: identical 11-key sequence, each key held stable while stalled, no skipped or duplicated idx.
- Start while busy:
  - Stimulus: second start with a different key at idx=5.
  - Response: sequence continues unchanged to idx0; the second key is never output.
- Reset mid-stream:
  - Stimulus: rst at idx=4.
  - Response: next cycle key_valid=0, busy=0, round_idx=0, round_key=0, no done.
  - A new start then yields idx10 one cycle later.
- Back-to-back runs:
  - Stimulus: start asserted in the done cycle with last_key_in=13111d7fe3944a17f307a78b4d2b30c5 (FIPS-197 C.1 round-10 key).
  - Response: second run ends with idx0=000102030405060708090a0b0c0d0e0f.
- Idle robustness:
  - Stimulus: key_ready=1 with no start for 20 cycles.
  - Response: key_valid, busy and done stay 0.
